// File: rtl/vga_pkg.sv
// Shared VGA timing types: one struct describes a complete video mode.
// Used by the generator and by the receive-side monitor.
package vga_pkg;

    typedef struct packed {
        int unsigned h_visible;
        int unsigned h_front_porch;
        int unsigned h_sync_pulse;
        int unsigned h_back_porch;
        int unsigned v_visible;
        int unsigned v_front_porch;
        int unsigned v_sync_pulse;
        int unsigned v_back_porch;
        bit          h_sync_active_low;
        bit          v_sync_active_low;
        int unsigned pixel_x_bits;
        int unsigned pixel_y_bits;
    } vga_params_t;

    localparam vga_params_t VGA_640X480 = '{
        h_visible:         640,
        h_front_porch:     16,
        h_sync_pulse:      96,
        h_back_porch:      48,
        v_visible:         480,
        v_front_porch:     10,
        v_sync_pulse:      2,
        v_back_porch:      33,
        h_sync_active_low: 1'b1,
        v_sync_active_low: 1'b1,
        pixel_x_bits:      10,
        pixel_y_bits:      10
    };

endpackage

// File: rtl/vga_sync_monitor_if.sv
// Raw VGA video bundle: sync pair plus one-bit RGB.
// The source drives it (master); the monitor samples it (slave).
interface vga_sync_monitor_if;

    logic h_sync;
    logic v_sync;
    logic pix_R;
    logic pix_G;
    logic pix_B;

    modport master (
        output h_sync,
        output v_sync,
        output pix_R,
        output pix_G,
        output pix_B
    );

    modport slave (
        input h_sync,
        input v_sync,
        input pix_R,
        input pix_G,
        input pix_B
    );

endinterface

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA checker: recovers pixel position, measures timing,
// tracks lock against the expected mode and counts lit pixels per frame.
module vga_sync_monitor
    import vga_pkg::*;
#(
    parameter vga_params_t params      = VGA_640X480,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic                           VGA_clk,
    input  logic                           reset_n,
    vga_sync_monitor_if.slave              vid,
    output logic [params.pixel_x_bits-1:0] rx_pixel_x,
    output logic [params.pixel_y_bits-1:0] rx_pixel_y,
    output logic                           rx_video_on,
    output logic                           rx_R,
    output logic                           rx_G,
    output logic                           rx_B,
    output logic                           locked,
    output logic                           h_err,
    output logic                           v_err,
    output logic                           timeout,
    output logic [7:0]                     lock_loss_count,
    output logic [15:0]                    meas_h_total,
    output logic [15:0]                    meas_h_sync_width,
    output logic [15:0]                    meas_v_total,
    output logic [19:0]                    frame_lit_count,
    output logic                           frame_done
);

    localparam int unsigned XW = params.pixel_x_bits;
    localparam int unsigned YW = params.pixel_y_bits;

    localparam int unsigned H_TOTAL = params.h_visible
                                    + params.h_front_porch
                                    + params.h_sync_pulse
                                    + params.h_back_porch;
    localparam int unsigned V_TOTAL = params.v_visible
                                    + params.v_front_porch
                                    + params.v_sync_pulse
                                    + params.v_back_porch;

    localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_VIS    = 16'(params.h_visible);
    localparam logic [15:0] V_VIS    = 16'(params.v_visible);
    localparam logic [15:0] HS_START = 16'(params.h_visible
                                         + params.h_front_porch);
    localparam logic [15:0] HS_NEXT  = HS_START + 16'd1;
    localparam logic [15:0] VS_START = 16'(params.v_visible
                                         + params.v_front_porch);
    localparam logic [15:0] HS_WIDTH = 16'(params.h_sync_pulse);
    localparam logic [15:0] TO_COUNT = 16'(2 * H_TOTAL);
    localparam logic [7:0]  GOOD_TOP = 8'(LOCK_FRAMES - 1);
    localparam logic        HS_POL   = params.h_sync_active_low;
    localparam logic        VS_POL   = params.v_sync_active_low;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    logic        hs1_q,        hs1_d;
    logic        vs1_q,        vs1_d;
    logic [2:0]  rgb1_q,       rgb1_d;
    logic        hs_prev_q,    hs_prev_d;
    logic        vs_prev_q,    vs_prev_d;
    logic [1:0]  live_q,       live_d;
    logic [15:0] h_pos_q,      h_pos_d;
    logic [15:0] v_pos_q,      v_pos_d;
    logic [15:0] line_cnt_q,   line_cnt_d;
    logic [15:0] width_cnt_q,  width_cnt_d;
    logic [15:0] hedge_cnt_q,  hedge_cnt_d;
    logic [15:0] m_htot_q,     m_htot_d;
    logic [15:0] m_hsw_q,      m_hsw_d;
    logic [15:0] m_vtot_q,     m_vtot_d;
    logic [19:0] lit_acc_q,    lit_acc_d;
    logic [19:0] frame_lit_q,  frame_lit_d;
    logic        frame_done_q, frame_done_d;
    state_t      state_q,      state_d;
    logic [7:0]  good_q,       good_d;
    logic        err_seen_q,   err_seen_d;
    logic [7:0]  lock_loss_q,  lock_loss_d;

    logic hs_act;
    logic vs_act;
    logic h_edge;
    logic h_fall;
    logic v_edge;
    logic h_err_c;
    logic v_err_c;
    logic timeout_c;
    logic vis;
    logic video_on;
    logic any_err;
    logic h_wrap;

    function automatic logic [15:0] inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Edges only count once both the sample and its delayed copy are real.
    always_comb begin
        hs_act    = hs1_q ^ HS_POL;
        vs_act    = vs1_q ^ VS_POL;
        h_edge    = live_q[1] & hs_act & ~hs_prev_q;
        h_fall    = live_q[1] & ~hs_act & hs_prev_q;
        v_edge    = live_q[1] & vs_act & ~vs_prev_q;
        h_err_c   = (h_edge && (h_pos_q != HS_START))
                  || (h_fall && (width_cnt_q != HS_WIDTH));
        v_err_c   = v_edge && ((v_pos_q != VS_START)
                  || (h_pos_q != 16'd0));
        timeout_c = (line_cnt_q == TO_COUNT);
        any_err   = h_err_c | v_err_c;
        vis       = (h_pos_q < H_VIS) && (v_pos_q < V_VIS);
        video_on  = (state_q == LOCKED) && vis;
        h_wrap    = !h_edge && (h_pos_q >= H_LAST);
    end

    always_comb begin
        hs1_d     = vid.h_sync;
        vs1_d     = vid.v_sync;
        rgb1_d    = {vid.pix_R, vid.pix_G, vid.pix_B};
        hs_prev_d = hs_act;
        vs_prev_d = vs_act;
        live_d    = {live_q[0], 1'b1};

        h_pos_d = h_pos_q + 16'd1;
        if (h_edge) begin
            h_pos_d = HS_NEXT;
        end else if (h_wrap) begin
            h_pos_d = 16'd0;
        end

        v_pos_d = v_pos_q;
        if (v_edge) begin
            v_pos_d = VS_START;
        end else if (h_wrap) begin
            v_pos_d = (v_pos_q >= V_LAST) ? 16'd0 : v_pos_q + 16'd1;
        end

        line_cnt_d = h_edge ? 16'd1 : inc16(line_cnt_q);
        m_htot_d   = h_edge ? line_cnt_q : m_htot_q;

        width_cnt_d = width_cnt_q;
        if (h_edge) begin
            width_cnt_d = 16'd1;
        end else if (hs_act) begin
            width_cnt_d = inc16(width_cnt_q);
        end
        m_hsw_d = h_fall ? width_cnt_q : m_hsw_q;

        hedge_cnt_d = h_edge ? inc16(hedge_cnt_q) : hedge_cnt_q;
        if (v_edge) begin
            hedge_cnt_d = {15'd0, h_edge};
        end
        m_vtot_d = v_edge ? hedge_cnt_q : m_vtot_q;

        lit_acc_d = lit_acc_q;
        if (v_edge) begin
            lit_acc_d = 20'd0;
        end else if (video_on && (|rgb1_q)
                     && (lit_acc_q != 20'hFFFFF)) begin
            lit_acc_d = lit_acc_q + 20'd1;
        end
        frame_lit_d  = v_edge ? lit_acc_q : frame_lit_q;
        frame_done_d = v_edge;
    end

    // Errors outrank a good-frame increment landing in the same cycle.
    always_comb begin
        state_d     = state_q;
        good_d      = good_q;
        err_seen_d  = err_seen_q;
        lock_loss_d = lock_loss_q;

        if (timeout_c) begin
            state_d    = SEARCH;
            good_d     = 8'd0;
            err_seen_d = 1'b0;
            if (state_q == LOCKED && lock_loss_q != 8'hFF) begin
                lock_loss_d = lock_loss_q + 8'd1;
            end
        end else begin
            unique case (state_q)
                SEARCH: begin
                    if (v_edge) begin
                        state_d    = TRACK;
                        good_d     = 8'd0;
                        err_seen_d = 1'b0;
                    end
                end
                TRACK: begin
                    if (any_err) begin
                        good_d     = 8'd0;
                        err_seen_d = !v_edge;
                    end else if (v_edge) begin
                        err_seen_d = 1'b0;
                        if (!err_seen_q) begin
                            if (good_q >= GOOD_TOP) begin
                                state_d = LOCKED;
                            end else begin
                                good_d = good_q + 8'd1;
                            end
                        end
                    end
                end
                LOCKED: begin
                    if (any_err) begin
                        state_d    = SEARCH;
                        good_d     = 8'd0;
                        err_seen_d = 1'b0;
                        if (lock_loss_q != 8'hFF) begin
                            lock_loss_d = lock_loss_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge VGA_clk or negedge reset_n) begin
        if (!reset_n) begin
            hs1_q        <= 1'b0;
            vs1_q        <= 1'b0;
            rgb1_q       <= 3'd0;
            hs_prev_q    <= 1'b0;
            vs_prev_q    <= 1'b0;
            live_q       <= 2'd0;
            h_pos_q      <= 16'd0;
            v_pos_q      <= 16'd0;
            line_cnt_q   <= 16'd0;
            width_cnt_q  <= 16'd0;
            hedge_cnt_q  <= 16'd0;
            m_htot_q     <= 16'd0;
            m_hsw_q      <= 16'd0;
            m_vtot_q     <= 16'd0;
            lit_acc_q    <= 20'd0;
            frame_lit_q  <= 20'd0;
            frame_done_q <= 1'b0;
            state_q      <= SEARCH;
            good_q       <= 8'd0;
            err_seen_q   <= 1'b0;
            lock_loss_q  <= 8'd0;
        end else begin
            hs1_q        <= hs1_d;
            vs1_q        <= vs1_d;
            rgb1_q       <= rgb1_d;
            hs_prev_q    <= hs_prev_d;
            vs_prev_q    <= vs_prev_d;
            live_q       <= live_d;
            h_pos_q      <= h_pos_d;
            v_pos_q      <= v_pos_d;
            line_cnt_q   <= line_cnt_d;
            width_cnt_q  <= width_cnt_d;
            hedge_cnt_q  <= hedge_cnt_d;
            m_htot_q     <= m_htot_d;
            m_hsw_q      <= m_hsw_d;
            m_vtot_q     <= m_vtot_d;
            lit_acc_q    <= lit_acc_d;
            frame_lit_q  <= frame_lit_d;
            frame_done_q <= frame_done_d;
            state_q      <= state_d;
            good_q       <= good_d;
            err_seen_q   <= err_seen_d;
            lock_loss_q  <= lock_loss_d;
        end
    end

    assign rx_pixel_x        = vis ? h_pos_q[XW-1:0] : '0;
    assign rx_pixel_y        = vis ? v_pos_q[YW-1:0] : '0;
    assign rx_video_on       = video_on;
    assign rx_R              = rgb1_q[2] & video_on;
    assign rx_G              = rgb1_q[1] & video_on;
    assign rx_B              = rgb1_q[0] & video_on;
    assign locked            = (state_q == LOCKED);
    assign h_err             = h_err_c;
    assign v_err             = v_err_c;
    assign timeout           = timeout_c;
    assign lock_loss_count   = lock_loss_q;
    assign meas_h_total      = m_htot_q;
    assign meas_h_sync_width = m_hsw_q;
    assign meas_v_total      = m_vtot_q;
    assign frame_lit_count   = frame_lit_q;
    assign frame_done        = frame_done_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor on a small mode (32x20 totals).
// A bench-side generator drives video; expected pixels queue per cycle.
module tb_vga_sync_monitor;
    import vga_pkg::*;

    localparam vga_params_t P = '{
        h_visible:         16,
        h_front_porch:     4,
        h_sync_pulse:      6,
        h_back_porch:      6,
        v_visible:         12,
        v_front_porch:     2,
        v_sync_pulse:      2,
        v_back_porch:      4,
        h_sync_active_low: 1'b1,
        v_sync_active_low: 1'b1,
        pixel_x_bits:      10,
        pixel_y_bits:      10
    };

    localparam int HT  = 32;
    localparam int VT  = 20;
    localparam int HV  = 16;
    localparam int VV  = 12;
    localparam int HSS = 20;
    localparam int HSW = 6;
    localparam int VSS = 14;
    localparam int VSW = 2;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       von;
        logic       r;
        logic       g;
        logic       b;
    } exp_t;

    logic        VGA_clk;
    logic        reset_n;
    logic [9:0]  rx_pixel_x;
    logic [9:0]  rx_pixel_y;
    logic        rx_video_on;
    logic        rx_R;
    logic        rx_G;
    logic        rx_B;
    logic        locked;
    logic        h_err;
    logic        v_err;
    logic        timeout;
    logic [7:0]  lock_loss_count;
    logic [15:0] meas_h_total;
    logic [15:0] meas_h_sync_width;
    logic [15:0] meas_v_total;
    logic [19:0] frame_lit_count;
    logic        frame_done;

    vga_sync_monitor_if vif();

    vga_sync_monitor #(
        .params      (P),
        .LOCK_FRAMES (2)
    ) dut (
        .VGA_clk           (VGA_clk),
        .reset_n           (reset_n),
        .vid               (vif.slave),
        .rx_pixel_x        (rx_pixel_x),
        .rx_pixel_y        (rx_pixel_y),
        .rx_video_on       (rx_video_on),
        .rx_R              (rx_R),
        .rx_G              (rx_G),
        .rx_B              (rx_B),
        .locked            (locked),
        .h_err             (h_err),
        .v_err             (v_err),
        .timeout           (timeout),
        .lock_loss_count   (lock_loss_count),
        .meas_h_total      (meas_h_total),
        .meas_h_sync_width (meas_h_sync_width),
        .meas_v_total      (meas_v_total),
        .frame_lit_count   (frame_lit_count),
        .frame_done        (frame_done)
    );

    initial VGA_clk = 1'b0;
    always #5 VGA_clk = ~VGA_clk;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   hc = 0;
    int   vc = 0;
    int   drv_hc = -1;
    int   drv_vc = -1;
    int   pattern = 0;
    int   skew_line = -1;
    bit   hold_hs = 0;
    bit   invert = 0;
    bit   chk_pix = 0;
    bit   seen_lock = 0;
    int   vedges = 0;
    int   n_herr = 0;
    int   n_to = 0;
    int   n_fd = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        exp_t e;
        int   hstart;
        logic hs, vs, vis, r, g, b;
        hstart = (vc == skew_line) ? HSS + 1 : HSS;
        hs  = (hc >= hstart) && (hc < hstart + HSW) && !hold_hs;
        vs  = (vc >= VSS) && (vc < VSS + VSW);
        vis = (hc < HV) && (vc < VV);
        r = 1'b0; g = 1'b0; b = 1'b0;
        if (pattern == 0) begin
            r = vis; g = vis; b = vis;
        end else if (pattern == 1) begin
            r = vis && (((hc + vc) % 2) == 0);
        end
        vif.h_sync = invert ? hs : ~hs;
        vif.v_sync = invert ? vs : ~vs;
        vif.pix_R  = r;
        vif.pix_G  = g;
        vif.pix_B  = b;
        if (vs && hc == 0 && vc == VSS) vedges++;
        e.x   = vis ? 10'(hc) : 10'd0;
        e.y   = vis ? 10'(vc) : 10'd0;
        e.von = vis;
        e.r = r; e.g = g; e.b = b;
        sb.push_back(e);
        drv_hc = hc;
        drv_vc = vc;
        hc = hc + 1;
        if (hc == HT) begin
            hc = 0;
            vc = (vc + 1) % VT;
        end
    endtask

    // Check the sample driven last cycle, then drive the next one.
    task automatic cyc();
        exp_t e;
        @(negedge VGA_clk);
        if (h_err) n_herr++;
        if (timeout) n_to++;
        if (frame_done) n_fd++;
        if (locked) seen_lock = 1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (chk_pix) begin
                check("pixel",
                      32'({rx_pixel_x, rx_pixel_y, rx_video_on,
                           rx_R, rx_G, rx_B}),
                      32'({e.x, e.y, e.von, e.r, e.g, e.b}));
            end
        end
        drive();
    endtask

    task automatic run_vedges(input int n);
        int target;
        target = vedges + n;
        for (int i = 0; i < HT * VT * (n + 1) && vedges < target; i++)
            cyc();
        check("vedge_wait", 32'(vedges >= target), 32'd1);
    endtask

    task automatic wait_pos(input int v, input int h);
        for (int i = 0; i < HT * VT + 2; i++) begin
            if (drv_vc == v && drv_hc == h) break;
            cyc();
        end
        check("pos_wait", 32'(drv_vc == v && drv_hc == h), 32'd1);
    endtask

    task automatic lock_after_3(input string tag);
        run_vedges(3);
        cyc();
        check({tag, "_pre"}, 32'(locked), 32'd0);
        cyc();
        check(tag, 32'(locked), 32'd1);
    endtask

    initial begin
        reset_n    = 1'b0;
        vif.h_sync = 1'b1;
        vif.v_sync = 1'b1;
        vif.pix_R  = 1'b0;
        vif.pix_G  = 1'b0;
        vif.pix_B  = 1'b0;
        repeat (3) @(negedge VGA_clk);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_errs", 32'({h_err, v_err, timeout, frame_done}), 32'd0);
        check("rst_pix", 32'({rx_pixel_x, rx_pixel_y, rx_video_on}), 32'd0);
        check("rst_meas", 32'(meas_h_total | meas_v_total), 32'd0);
        check("rst_lit", 32'(frame_lit_count), 32'd0);
        reset_n = 1'b1;

        lock_after_3("lock_initial");
        check("loss_none", 32'(lock_loss_count), 32'd0);
        chk_pix = 1;
        n_fd = 0;
        run_vedges(1);
        cyc();
        check("fdone_pre", 32'(frame_done), 32'd0);
        cyc();
        check("fdone", 32'(frame_done), 32'd1);
        check("fdone_once", 32'(n_fd), 32'd1);
        check("lit_white", 32'(frame_lit_count), 32'd192);
        check("meas_htot", 32'(meas_h_total), 32'd32);
        check("meas_hsw", 32'(meas_h_sync_width), 32'd6);
        check("meas_vtot", 32'(meas_v_total), 32'd20);

        pattern = 1;
        n_fd = 0;
        run_vedges(1);
        cyc();
        cyc();
        check("lit_checker", 32'(frame_lit_count), 32'd96);
        check("fdone_once2", 32'(n_fd), 32'd1);
        pattern = 0;

        skew_line = 5;
        wait_pos(5, 0);
        chk_pix = 0;
        n_herr = 0;
        wait_pos(6, 10);
        skew_line = -1;
        check("skew_herr", 32'(n_herr), 32'd1);
        check("skew_unlock", 32'(locked), 32'd0);
        check("skew_loss", 32'(lock_loss_count), 32'd1);
        lock_after_3("relock_skew");
        chk_pix = 1;

        wait_pos(5, 27);
        chk_pix = 0;
        n_to = 0;
        hold_hs = 1;
        repeat (96) cyc();
        hold_hs = 0;
        check("to_once", 32'(n_to), 32'd1);
        check("to_unlock", 32'(locked), 32'd0);
        check("to_loss", 32'(lock_loss_count), 32'd2);
        wait_pos(9, 3);
        cyc();
        check("to_video_off", 32'(rx_video_on), 32'd0);
        lock_after_3("relock_to");

        wait_pos(3, 10);
        reset_n = 1'b0;
        #1;
        check("mid_rst_lock", 32'({locked, lock_loss_count}), 32'd0);
        check("mid_rst_meas",
              32'(meas_h_total | meas_h_sync_width | meas_v_total),
              32'd0);
        check("mid_rst_lit", 32'(frame_lit_count), 32'd0);
        check("mid_rst_pix",
              32'({rx_pixel_x, rx_pixel_y, rx_video_on, rx_R}), 32'd0);
        repeat (3) cyc();
        reset_n = 1'b1;
        run_vedges(1);
        cyc();
        cyc();
        check("mid_rst_nopartial", 32'(frame_lit_count), 32'd0);
        run_vedges(2);
        cyc();
        check("mid_rst_relock_pre", 32'(locked), 32'd0);
        cyc();
        check("mid_rst_relock", 32'(locked), 32'd1);

        reset_n = 1'b0;
        invert = 1;
        repeat (2) cyc();
        reset_n = 1'b1;
        n_herr = 0;
        seen_lock = 0;
        run_vedges(4);
        check("pol_never_lock", 32'(seen_lock), 32'd0);
        check("pol_herr_many", 32'(n_herr >= 40), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
